// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-writer and bit-level command codes, the
// write-direction RW bit, and the write sequencer state encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    BCMD_IDLE  = 3'b000,
    BCMD_START = 3'b001,
    BCMD_ACK   = 3'b010,
    BCMD_DATA  = 3'b011,
    BCMD_STOP  = 3'b100,
    BCMD_NACK  = 3'b101
  } byte_cmd_e;

  typedef enum logic [2:0] {
    BIT_IDLE  = 3'b000,
    BIT_START = 3'b001,
    BIT_WRITE = 3'b010,
    BIT_READ  = 3'b011,
    BIT_STOP  = 3'b100
  } bit_cmd_e;

  localparam logic RW_W = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ADDR_ACK, ST_FETCH,
    ST_DATA, ST_DATA_ACK, ST_STOP, ST_DONE
  } seq_state_e;

  // States that hand a command to the byte writer
  function automatic logic is_byte_state(seq_state_e s);
    return (s == ST_START) || (s == ST_ADDR) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

  // States that wait on the ACK-sampling receiver
  function automatic logic is_ack_state(seq_state_e s);
    return (s == ST_ADDR_ACK) || (s == ST_DATA_ACK);
  endfunction

  function automatic byte_cmd_e cmd_for_state(seq_state_e s);
    case (s)
      ST_START:        return BCMD_START;
      ST_ADDR, ST_DATA: return BCMD_DATA;
      ST_STOP:         return BCMD_STOP;
      default:         return BCMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_tx_shifter.sv
// 8-bit parallel-load shift register; MSB is the serial bit on the wire.
// Each load strobe shifts left by one, filling the LSB with 0.
module i2c_tx_shifter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  output logic       msb
);

  logic [7:0] shift_reg;

  // Parallel load wins over shift; the two never coincide in normal flow
  always_ff @(posedge clock) begin
    if (reset)      shift_reg <= '0;
    else if (load)  shift_reg <= load_data;
    else if (shift) shift_reg <= {shift_reg[6:0], 1'b0};
  end

  assign msb = shift_reg[7];

endmodule

// File: rtl/i2c_master_write_sequencer.sv
// Write transaction sequencer: START, address+W, payload bytes, STOP,
// collecting the slave ACK after each byte and aborting on NACK.
module i2c_master_write_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              nack_err,
  output logic              byte_go,
  output logic [2:0]        byte_command,
  output logic              byte_data,
  input  logic              byte_load,
  input  logic              byte_finish,
  output logic              ack_go,
  input  logic              ack_finish,
  input  logic              ack_value
);

  seq_state_e        state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              nack_q;
  logic              sh_load, sh_shift;
  logic [7:0]        sh_load_data;
  logic              byte_done, ack_done;

  // A finish only counts while the matching go is actually raised
  assign byte_done = byte_go & byte_finish;
  assign ack_done  = ack_go & ack_finish;

  // Next state, shifter control and the stream handshake
  always_comb begin
    state_d      = state;
    sh_load      = 1'b0;
    sh_load_data = '0;
    tx_ready     = 1'b0;
    case (state)
      ST_IDLE:  if (req) state_d = ST_START;
      ST_START: if (byte_done) begin
        state_d      = ST_ADDR;
        sh_load      = 1'b1;
        sh_load_data = {addr_q, RW_W};
      end
      ST_ADDR:  if (byte_done) state_d = ST_ADDR_ACK;
      ST_ADDR_ACK, ST_DATA_ACK:
        if (ack_done) state_d = (ack_value || rem_q == '0) ? ST_STOP : ST_FETCH;
      ST_FETCH: if (tx_valid) begin
        tx_ready     = 1'b1;
        sh_load      = 1'b1;
        sh_load_data = tx_data;
        state_d      = ST_DATA;
      end
      ST_DATA:  if (byte_done) state_d = ST_DATA_ACK;
      ST_STOP:  if (byte_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign sh_shift = byte_load & ((state == ST_ADDR) | (state == ST_DATA));

  // State and registered go/command; go drops on the edge its finish is seen
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      byte_go      <= 1'b0;
      ack_go       <= 1'b0;
      byte_command <= BCMD_IDLE;
    end else begin
      state        <= state_d;
      byte_go      <= is_byte_state(state_d) & ~byte_done;
      ack_go       <= is_ack_state(state_d) & ~ack_done;
      byte_command <= cmd_for_state(state_d);
    end
  end

  // Request capture, payload countdown and sticky NACK flag
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      nack_q <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      addr_q <= req_addr;
      rem_q  <= req_len;
      nack_q <= 1'b0;
    end else begin
      if (tx_ready && rem_q != '0) rem_q <= rem_q - 1'b1;
      if (is_ack_state(state) && ack_done && ack_value) nack_q <= 1'b1;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign nack_err = done & nack_q;

  i2c_tx_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .msb       (byte_data)
  );

endmodule

// File: tb/tb_i2c_master_write_sequencer.sv
// Bench for the write sequencer: byte-writer, ACK-receiver and stream
// models around the DUT, a scoreboard of expected bus events, and a
// vector table plus a mid-transfer reset sequence.
module tb_i2c_master_write_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [6:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, nack_err, byte_go, byte_data, ack_go;
  logic [2:0] byte_command;
  logic       byte_load = 1'b0, byte_finish = 1'b0;
  logic       ack_finish = 1'b0, ack_value = 1'b0;

  always #5 clock = ~clock;

  i2c_master_write_sequencer #(.LEN_W(4), .ADDR_W(7)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .nack_err(nack_err), .byte_go(byte_go), .byte_command(byte_command),
    .byte_data(byte_data), .byte_load(byte_load), .byte_finish(byte_finish),
    .ack_go(ack_go), .ack_finish(ack_finish), .ack_value(ack_value)
  );

  typedef struct {
    logic [6:0] addr;
    logic [3:0] len;
    logic [7:0] b0, b1, b2;
    int         nack;      // ACK index answered with NACK (0 = address), -1 none
    int         stall;     // cycles tx_valid is held low after the address ACK
    bit         poke;      // pulse req while busy
    int         exp_ready;
    logic       exp_nack;
  } vec_t;

  int checks = 0, errors = 0;
  logic [11:0] exp_q[$];   // {kind, value}: 1 START, 2 DATA byte, 3 STOP, 4 DONE
  logic [7:0]  src_q[$];
  int  stall_cnt = 0, nack_idx = -1, ack_cnt = 0, src_cons = 0;
  bit  kill_wr = 0, wr_is_data = 0, consume = 0;
  int  wr_loads = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [11:0] got);
    logic [11:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s got %h expected no event", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s got %h expected %h", name, got, e);
      end
    end
  endtask

  function automatic logic [3:0] kind_of(input logic [2:0] c);
    case (c)
      3'b001:  return 4'd1;
      3'b011:  return 4'd2;
      3'b100:  return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  // Byte writer model: samples byte_data before each load, finish on the 8th load
  initial begin : writer
    logic [7:0] bits;
    logic [3:0] kind;
    bit aborted;
    forever begin
      @(negedge clock);
      if (byte_go && !kill_wr) begin
        aborted = 0; bits = '0; wr_loads = 0;
        kind = kind_of(byte_command);
        if (kind == 4'd2) begin
          wr_is_data = 1;
          for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (kill_wr) begin aborted = 1; byte_load = 0; byte_finish = 0; break; end
            wr_loads = i;
            bits = {bits[6:0], byte_data};
            byte_load = 1'b1;
            byte_finish = (i == 7);
            @(negedge clock);
            byte_load = 1'b0;
            byte_finish = 1'b0;
            if (kill_wr) begin aborted = 1; break; end
          end
        end else begin
          @(negedge clock);
          @(negedge clock);
          if (kill_wr) aborted = 1;
          else begin
            byte_finish = 1'b1;
            @(negedge clock);
            byte_finish = 1'b0;
          end
        end
        wr_is_data = 0;
        if (!aborted) begin
          check("byte_go_release", {31'd0, byte_go}, 32'd0);
          sb_check("byte_event", {kind, (kind == 4'd2) ? bits : 8'h00});
        end
      end
    end
  end

  // ACK receiver model
  initial begin : acker
    forever begin
      @(negedge clock);
      if (ack_go && !kill_wr) begin
        @(negedge clock);
        ack_value  = (ack_cnt == nack_idx);
        ack_finish = 1'b1;
        @(negedge clock);
        ack_finish = 1'b0;
        ack_value  = 1'b0;
        ack_cnt++;
        check("ack_go_release", {31'd0, ack_go}, 32'd0);
      end
    end
  end

  // Payload stream source with optional stall after the address ACK
  initial begin : source
    forever begin
      @(negedge clock);
      if (consume) begin
        void'(src_q.pop_front());
        src_cons++;
        consume = 0;
      end
      if (stall_cnt > 0) begin
        tx_valid = 1'b0;
        if (ack_cnt >= 1) stall_cnt--;
      end else begin
        tx_valid = (src_q.size() > 0);
      end
      tx_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
      #1;
      consume = tx_valid && tx_ready;
    end
  end

  task automatic start_xfer(input vec_t v);
    logic [7:0] bs[3];
    bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
    exp_q.delete(); src_q.delete();
    ack_cnt = 0; src_cons = 0; nack_idx = v.nack; stall_cnt = v.stall;
    for (int i = 0; i < int'(v.len); i++) src_q.push_back(bs[i]);
    exp_q.push_back({4'd1, 8'h00});
    exp_q.push_back({4'd2, v.addr, 1'b0});
    if (v.nack != 0) begin
      for (int i = 0; i < int'(v.len); i++) begin
        exp_q.push_back({4'd2, bs[i]});
        if (v.nack == i + 1) break;
      end
    end
    exp_q.push_back({4'd3, 8'h00});
    exp_q.push_back({4'd4, 7'd0, v.exp_nack});
    @(negedge clock);
    req = 1'b1; req_addr = v.addr; req_len = v.len;
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic finish_xfer(input vec_t v);
    int cyc = 0, stall_obs = 0, stall_bad = 0;
    bit seen = 0;
    while (cyc < 3000) begin
      @(negedge clock); #2;
      cyc++;
      if (stall_cnt > 0 && ack_cnt >= 1) begin
        stall_obs++;
        if (byte_go || !busy || tx_ready) stall_bad++;
      end
      if (v.poke && cyc == 10) begin req = 1'b1; req_addr = 7'h7E; req_len = 4'd5; end
      if (v.poke && cyc == 11) begin req = 1'b0; req_addr = v.addr; req_len = v.len; end
      if (done) begin seen = 1; break; end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      sb_check("done_event", {4'd4, 7'd0, nack_err});
      req = 1'b1; req_addr = 7'h12; req_len = 4'd0;   // ignored in the DONE cycle
      @(negedge clock); req = 1'b0; #2;
      check("busy_after_done", {30'd0, busy, byte_go}, 32'd0);
      @(negedge clock); #2;
      check("still_idle", {30'd0, busy, byte_go}, 32'd0);
    end
    check("tx_ready_count", src_cons, v.exp_ready);
    check("events_left", exp_q.size(), 32'd0);
    if (v.stall > 0) check("stall_hold", {stall_bad, (stall_obs >= 15)}, 32'd1);
  endtask

  task automatic run_xfer(input vec_t v);
    start_xfer(v);
    finish_xfer(v);
  endtask

  initial begin : main
    vec_t tbl[5];
    vec_t rv;
    bit hit;
    tbl[0] = '{7'h50, 4'd2, 8'hA5, 8'h3C, 8'h00, -1, 0,  0, 2, 1'b0};
    tbl[1] = '{7'h7F, 4'd0, 8'h00, 8'h00, 8'h00, -1, 0,  0, 0, 1'b0};
    tbl[2] = '{7'h22, 4'd2, 8'h11, 8'h22, 8'h00,  0, 0,  0, 0, 1'b1};
    tbl[3] = '{7'h3A, 4'd1, 8'hC3, 8'h00, 8'h00, -1, 20, 0, 1, 1'b0};
    tbl[4] = '{7'h01, 4'd3, 8'hFF, 8'h00, 8'h81,  3, 0,  1, 3, 1'b1};
    repeat (3) @(negedge clock);
    #2;
    check("reset_outputs",
          {22'd0, tx_ready, busy, done, nack_err, byte_go, byte_command, byte_data, ack_go}, 32'd0);
    reset = 1'b0;
    for (int t = 0; t < 5; t++) run_xfer(tbl[t]);

    // Reset while the 4th bit of the first payload byte is on the wire
    rv = '{7'h44, 4'd1, 8'h9A, 8'h00, 8'h00, -1, 0, 0, 1, 1'b0};
    start_xfer(rv);
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clock); #2;
      if (src_cons == 1 && wr_is_data && wr_loads == 3 && byte_load) begin hit = 1; break; end
    end
    check("reach_4th_bit", {31'd0, hit}, 32'd1);
    kill_wr = 1; reset = 1'b1;
    @(negedge clock); #2;
    check("mid_reset_outputs",
          {22'd0, tx_ready, busy, done, nack_err, byte_go, byte_command, byte_data, ack_go}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    kill_wr = 0;
    exp_q.delete(); src_q.delete();
    #2;
    check("idle_after_reset", {31'd0, busy}, 32'd0);
    run_xfer(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_write_sequencer.md
Name: i2c_master_write_sequencer

Overview:
- Upstream transaction controller for the I2C master byte writer.
- Accepts a write request: 7-bit slave address, byte count, and a ready/valid byte stream.
- Issues START, address+W, data bytes and STOP commands to the byte writer, and serialises each byte MSB-first on its `data` input, advancing on `load`.
- Collects the slave ACK after each byte through the bit-receive stage. On NACK it aborts with STOP and reports an error.

Parameters:
- LEN_W, 4: width of the byte-count field; max payload is 2^LEN_W-1 bytes.
- ADDR_W, 7: slave address width. Only 7 is supported; the parameter is for documentation.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request pulse; accepted only when busy=0
- req_addr  in  7  slave address, captured on accept
- req_len  in  LEN_W  number of data bytes, captured on accept; 0 is legal
- tx_data  in  8  next payload byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle pulse; byte consumed when tx_valid&tx_ready
- busy  out  1  high from the accept cycle until the done pulse, inclusive
- done  out  1  one-cycle completion pulse
- nack_err  out  1  asserted with done when the transfer was aborted by NACK
- byte_go  out  1  go to byte writer
- byte_command  out  3  to byte writer: IDLE=000, START=001, DATA=011, STOP=100
- byte_data  out  1  current serial bit = shift_reg[7]
- byte_load  in  1  byte writer bit-sent strobe; shift left by one
- byte_finish  in  1  byte writer completion strobe
- ack_go  out  1  go to the ACK-sampling bit receiver
- ack_finish  in  1  receiver completion strobe
- ack_value  in  1  sampled SDA; 0=ACK, 1=NACK, valid with ack_finish

Behaviour:
- Reset values:
  - state=IDLE, all outputs 0, byte_command=000.
  - shift_reg=0, remaining count=0.
  - Reset mid-transfer returns to IDLE the next edge. No STOP is generated; bus recovery is the system's job.
- Go handshake (byte_go and ack_go):
  - Registered. Raised on entry to the state that needs them.
  - Held until the matching finish is sampled high.
  - Cleared on the same edge the FSM leaves the state, so go is low the cycle after finish. This prevents the byte writer from restarting.
  - byte_command is registered and stable for the whole time byte_go is high.
- FSM states and transitions:
  - IDLE: req → capture addr/len, busy=1, → START. req while busy is ignored.
  - START: command=START. On byte_finish, shift_reg={addr,1'b0} → ADDR.
  - ADDR: command=DATA. byte_load shifts shift_reg left, filling LSB with 0. On byte_finish → ADDR_ACK.
  - ADDR_ACK: ack_go=1. On ack_finish:
    - ack_value=1 → set nack flag, → STOP.
    - otherwise, remaining=0 → STOP.
    - otherwise → FETCH.
  - FETCH: tx_ready=1 for exactly the cycle tx_valid is seen high. shift_reg=tx_data, remaining decrements → DATA. Waits indefinitely with byte_go=0 while tx_valid=0, so SCL is held by the byte writer's idle level.
  - DATA: same as ADDR. On byte_finish → DATA_ACK.
  - DATA_ACK: as ADDR_ACK. NACK on the last byte is still an error.
  - STOP: command=STOP. On byte_finish → DONE.
  - DONE: done=1 and nack_err=flag for one cycle; busy drops next cycle → IDLE.
- byte_data is valid from the cycle byte_go rises in ADDR/DATA. The byte writer samples it before its first load.
- Exactly 8 loads per byte are expected. Extra loads outside ADDR/DATA are ignored.
- Simultaneous events:
  - byte_finish coinciding with the 8th byte_load: the shift is applied and the state advances on the same edge.
  - req in the DONE cycle is ignored.
- Counter: remaining is LEN_W bits and never decrements below 0. len=0 produces START, addr, ACK, STOP.

Decomposition:
- Shared package i2c_pkg holds:
  - byte-writer command encodings (IDLE/START/DATA/ACK/NACK/STOP);
  - bit-level command encodings;
  - the RW bit constant W=0.
- One natural sub-module, i2c_tx_shifter: 8-bit parallel-load, load-strobe shift register exposing MSB. The FSM stays in this module.

Test Plan:
- Basic write: req addr=0x50, len=2, bytes 0xA5, 0x3C, slave always ACK.
  - byte_data sequence 1010000_0, 10100101, 00111100 (MSB first).
  - Commands START, DATA×3, STOP.
  - 2 tx_ready pulses; done=1, nack_err=0.
- Zero-length probe: req addr=0x7F, len=0.
  - START, DATA 11111110, ACK, STOP; no tx_ready; done=1.
- Address NACK: ack_value=1 after the address byte.
  - Next command is STOP; tx_ready never asserts; done=1, nack_err=1.
- Stalled stream: tx_valid held low 20 cycles in FETCH.
  - byte_go stays 0, busy stays 1.
  - When tx_valid rises, tx_ready pulses once and the transfer resumes.
- Go-release check: model byte writer finish.
  - byte_go is 0 in the cycle after every byte_finish; no duplicate transfer.
  - A req pulse while busy=1 is ignored.
- Reset mid-DATA: reset for 1 cycle during the 4th bit.
  - All outputs 0 next cycle, state IDLE.
  - A new req then completes normally.
